pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
Parametrised pipeline-register chain placed between two CPU stages, e.g. EX->MEM or MEM->WB. It carries instruction, PC, a generic payload bus, destination register, write enable, exception code and branch-delay flag through DEPTH register stages. Unlike a plain stage register it supports stall, bubble insertion, exception/interrupt flush, in-stage exception merging and a bubble-count statistic.

Parameters:
DATA_W, 32, payload width (caller concatenates ALU result, store data, forward data)
ADDR_W, 5, destination register address width
EXC_W, 5, exception code width; 0 = no exception
DEPTH, 1, number of chained register stages, legal 1..4
EXC_PC, 32'h0000_4180, PC loaded into all stages on req_i
CNT_W, 16, bubble counter width

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
stall_i  input  1  hold all stages
flush_i  input  1  insert bubble into stage 0
req_i  input  1  exception/interrupt request: kill all stages
instr_i  input  32  instruction
pc_i  input  32  instruction PC
data_i  input  DATA_W  payload
regaddr_i  input  ADDR_W  destination register
regwrite_i  input  1  register write enable
exccode_i  input  EXC_W  exception from earlier stages
exc_local_i  input  EXC_W  exception detected in current stage
bd_i  input  1  branch-delay-slot flag
instr_o  output  32  last-stage instruction
pc_o  output  32  last-stage PC
data_o  output  DATA_W  last-stage payload
regaddr_o  output  ADDR_W  last-stage destination
regwrite_o  output  1  last-stage write enable
exccode_o  output  EXC_W  last-stage exception code
bd_o  output  1  last-stage BD flag
valid_o  output  1  last stage holds a real instruction
bubble_cnt_o  output  CNT_W  bubbles inserted since reset

Behaviour:
- Reset, synchronous active-high; clock clk: all stages zero (instr, pc, data, regaddr, regwrite, exccode, bd, valid); bubble_cnt_o = 0. All outputs 0 during the cycle after reset.
- Per-edge priority: reset > req_i > stall_i > flush_i > normal advance.
- req_i: every stage loads instr 0, pc EXC_PC, data 0, regaddr 0, regwrite 0, exccode 0, bd 0, valid 0. Overrides a simultaneous stall_i or flush_i. bubble_cnt unchanged.
- stall_i (no req_i): every stage holds. flush_i is ignored in this cycle and the counter does not increment.
- flush_i (no stall_i, no req_i): stage 0 loads a bubble: instr 0, data 0, regaddr 0, regwrite 0, exccode 0, valid 0. pc and bd are copied from pc_i and bd_i so EPC stays correct if an interrupt lands on the bubble. Stages 1..DEPTH-1 shift normally. bubble_cnt increments and saturates at all-ones.
- Normal advance: stage k loads from stage k-1. Stage 0 loads inputs with valid 1.
  - merged exccode = exccode_i if nonzero, else exc_local_i. Earlier stage wins.
  - stored regwrite = regwrite_i AND (merged exccode == 0). Excepting instructions never write back.
- Latency: DEPTH clock edges from input to output when there is no stall.
- Outputs are taken directly from stage DEPTH-1 registers. No combinational input-to-output path.
- DEPTH = 1 degenerates to a single stage register with stall, flush and exception semantics.
- reset asserted mid-stall or mid-flush clears everything, including the counter.

Test Plan:
- Reset, then 3 consecutive inputs (pc 0x3000/0x3004/0x3008, regwrite 1, DEPTH=2) -> pc_o shows 0x3000 exactly 2 edges after first input, then 0x3004, 0x3008; valid_o 1.
- stall_i held 3 cycles with pc_i changing -> outputs frozen at prior values; bubble_cnt_o unchanged even with flush_i=1 concurrently.
- flush_i 1 cycle with pc_i 0x3010, bd_i 1 -> next output (DEPTH=1) instr 0, regwrite 0, valid 0, pc 0x3010, bd 1; bubble_cnt_o 1. Driving 65536 flushes with CNT_W=16 -> saturates at 0xFFFF.
- exccode_i 0, exc_local_i 5'd4, regwrite_i 1 -> exccode_o 4, regwrite_o 0. exccode_i 5'd10 with exc_local_i 4 -> exccode_o 10.
- req_i together with stall_i and flush_i -> all stages pc EXC_PC 0x4180, instr 0, valid 0 after one edge; counter unchanged.
- reset asserted during a stall with nonzero counter -> all outputs and bubble_cnt_o 0 on the next edge.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Stage-register bus: upstream instruction fields, pipeline control and
// last-stage outputs. The master drives the inputs; the register chain is the slave.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int EXC_W  = 5,
  parameter int CNT_W  = 16
);
  logic              stall_i;
  logic              flush_i;
  logic              req_i;
  logic [31:0]       instr_i;
  logic [31:0]       pc_i;
  logic [DATA_W-1:0] data_i;
  logic [ADDR_W-1:0] regaddr_i;
  logic              regwrite_i;
  logic [EXC_W-1:0]  exccode_i;
  logic [EXC_W-1:0]  exc_local_i;
  logic              bd_i;

  logic [31:0]       instr_o;
  logic [31:0]       pc_o;
  logic [DATA_W-1:0] data_o;
  logic [ADDR_W-1:0] regaddr_o;
  logic              regwrite_o;
  logic [EXC_W-1:0]  exccode_o;
  logic              bd_o;
  logic              valid_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  modport master (
    output stall_i, flush_i, req_i, instr_i, pc_i, data_i, regaddr_i,
           regwrite_i, exccode_i, exc_local_i, bd_i,
    input  instr_o, pc_o, data_o, regaddr_o, regwrite_o, exccode_o, bd_o,
           valid_o, bubble_cnt_o
  );

  modport slave (
    input  stall_i, flush_i, req_i, instr_i, pc_i, data_i, regaddr_i,
           regwrite_i, exccode_i, exc_local_i, bd_i,
    output instr_o, pc_o, data_o, regaddr_o, regwrite_o, exccode_o, bd_o,
           valid_o, bubble_cnt_o
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// DEPTH-deep pipeline register chain between CPU stages with stall, bubble
// insertion, exception flush, in-stage exception merging and a bubble counter.
module pipe_stage_reg #(
  parameter int          DATA_W = 32,
  parameter int          ADDR_W = 5,
  parameter int          EXC_W  = 5,
  parameter int          DEPTH  = 1,
  parameter logic [31:0] EXC_PC = 32'h0000_4180,
  parameter int          CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipe_stage_reg_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic [31:0]       instr;
    logic [31:0]       pc;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] regaddr;
    logic              regwrite;
    logic [EXC_W-1:0]  exccode;
    logic              bd;
  } stage_t;

  stage_t           stage_q [DEPTH];
  stage_t           in_stage;
  stage_t           bubble_stage;
  stage_t           exc_stage;
  logic [EXC_W-1:0] merged_exc;
  logic [CNT_W-1:0] bubble_cnt_q;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    merged_exc = (bus.exccode_i != '0) ? bus.exccode_i : bus.exc_local_i;

    in_stage          = '0;
    in_stage.valid    = 1'b1;
    in_stage.instr    = bus.instr_i;
    in_stage.pc       = bus.pc_i;
    in_stage.data     = bus.data_i;
    in_stage.regaddr  = bus.regaddr_i;
    // An excepting instruction must never reach write-back with its enable set.
    in_stage.regwrite = bus.regwrite_i && (merged_exc == '0);
    in_stage.exccode  = merged_exc;
    in_stage.bd       = bus.bd_i;

    // Bubbles keep pc/bd so EPC is right if an interrupt lands on the bubble.
    bubble_stage      = '0;
    bubble_stage.pc   = bus.pc_i;
    bubble_stage.bd   = bus.bd_i;

    exc_stage         = '0;
    exc_stage.pc      = EXC_PC;
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its predecessor's pre-edge value and the chain shifts by exactly one.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
      bubble_cnt_q <= '0;
    end else if (bus.req_i) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= exc_stage;
    end else if (!bus.stall_i) begin
      stage_q[0] <= bus.flush_i ? bubble_stage : in_stage;
      for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
      if (bus.flush_i && (bubble_cnt_q != '1)) bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  assign bus.instr_o      = stage_q[DEPTH-1].instr;
  assign bus.pc_o         = stage_q[DEPTH-1].pc;
  assign bus.data_o       = stage_q[DEPTH-1].data;
  assign bus.regaddr_o    = stage_q[DEPTH-1].regaddr;
  assign bus.regwrite_o   = stage_q[DEPTH-1].regwrite;
  assign bus.exccode_o    = stage_q[DEPTH-1].exccode;
  assign bus.bd_o         = stage_q[DEPTH-1].bd;
  assign bus.valid_o      = stage_q[DEPTH-1].valid;
  assign bus.bubble_cnt_o = bubble_cnt_q;

endmodule
